spi_register_bank: RTL

//   Consumes the byte stream from the SPI slave reader and runs a command/register protocol on it.
//   The first byte of a frame is a command: bit7=1 is write, 0 is read; bits[6:0] give the start address.

---
 rtl/spi_register_bank_if.sv | 19 +
 rtl/spi_register_bank.sv | 99 +++++++++
 2 files changed

// File: rtl/spi_register_bank_if.sv
// spi_register_bank_if: byte stream in, register bank and write strobe out
interface spi_register_bank_if #(parameter int NUM_REGS = 16);
  logic [7:0]            spi_data;
  logic                  spi_received;
  logic [7:0]            to_output;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_strobe;
  logic [6:0]            wr_addr;
  logic [7:0]            wr_data;
  logic                  frame_active;
  modport master (
    output spi_data, spi_received,
    input  to_output, regs_flat, wr_strobe, wr_addr, wr_data, frame_active
  );
  modport slave (
    input  spi_data, spi_received,
    output to_output, regs_flat, wr_strobe, wr_addr, wr_data, frame_active
  );
endinterface

// File: rtl/spi_register_bank.sv
// spi_register_bank: command/register protocol over a received SPI byte stream
module spi_register_bank #(
  parameter int         NUM_REGS       = 16,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input logic             clk,
  input logic             rst,
  spi_register_bank_if.slave bus
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {CMD, WRITE, READ} state_t;
  state_t        state_q, state_d;
  logic [6:0]    addr_q, addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    to_q, to_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [6:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          we;
  logic [7:0]    regs_q [NUM_REGS];
  function automatic logic [7:0] rd(input logic [6:0] a);
    rd = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) if (a == 7'(i)) rd = regs_q[i];
  endfunction
  // Frame sequencing: a received byte always wins over a pending timeout
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    to_d        = to_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we          = 1'b0;
    if (bus.spi_received) begin
      tmo_d = '0;
      case (state_q)
        CMD: begin
          addr_d  = bus.spi_data[6:0];
          state_d = bus.spi_data[7] ? WRITE : READ;
          to_d    = bus.spi_data[7] ? SYNC_BYTE : rd(bus.spi_data[6:0]);
        end
        WRITE: begin
          we          = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = bus.spi_data;
          addr_d      = addr_q + 7'd1;
        end
        default: begin
          addr_d = addr_q + 7'd1;
          to_d   = rd(addr_q + 7'd1);
        end
      endcase
    end else if (state_q != CMD) begin
      state_d = tmo_q == TMAX ? CMD : state_q;
      to_d    = tmo_q == TMAX ? SYNC_BYTE : to_q;
      tmo_d   = tmo_q == TMAX ? '0 : tmo_q + 1'b1;
    end
  end
  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CMD;
      addr_q      <= '0;
      tmo_q       <= '0;
      to_q        <= SYNC_BYTE;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      to_q        <= to_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end
  // Register array; addresses beyond the implemented range match no entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) if (addr_q == 7'(i)) regs_q[i] <= bus.spi_data;
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.regs_flat[8*g +: 8] = regs_q[g];
  end
  assign bus.to_output    = to_q;
  assign bus.wr_strobe    = wr_strobe_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.frame_active = state_q != CMD;
endmodule
